// File: rtl/servo_pkg.sv
// servo_pkg: shared timing defaults and clamp helper for the servo PWM path.
// Defaults target a 50 Hz frame at 100 MHz. One tick is 3.9 us, and a 1..2 ms
// pulse is 256..512 ticks.
package servo_pkg;

  localparam int SERVO_PRESC        = 390;
  localparam int SERVO_PERIOD_TICKS = 5128;
  localparam int SERVO_OFFSET       = 384;
  localparam int SERVO_MIN_DUTY     = 256;
  localparam int SERVO_MAX_DUTY     = 512;

  function automatic int servo_clamp(input int v, input int lo, input int hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/servo_scale_sat.sv
// servo_scale_sat: combinational scaling of a signed controller sample into a
// legal servo pulse width.
//   i_data : signed controller sample
//   o_duty : clamp((i_data >>> SHIFT) + OFFSET, MIN_DUTY, MAX_DUTY)
//   o_sat  : 1 when the clamp changed the value
module servo_scale_sat
  import servo_pkg::*;
#(
  parameter int IN_BITS   = 13,
  parameter int DUTY_BITS = 13,
  parameter int SHIFT     = 4,
  parameter int OFFSET    = SERVO_OFFSET,
  parameter int MIN_DUTY  = SERVO_MIN_DUTY,
  parameter int MAX_DUTY  = SERVO_MAX_DUTY
) (
  input  logic signed [IN_BITS-1:0]   i_data,
  output logic        [DUTY_BITS-1:0] o_duty,
  output logic                        o_sat
);

  // Two guard bits keep the sum from wrapping before the clamp sees it.
  localparam int VW = IN_BITS + 2;
  localparam logic signed [VW-1:0] OFF_V = VW'(OFFSET);

  logic signed [VW-1:0] w_ext;
  logic signed [VW-1:0] w_v;
  int                   w_vi;

  assign w_ext  = {{2{i_data[IN_BITS-1]}}, i_data};
  assign w_v    = (w_ext >>> SHIFT) + OFF_V;
  assign w_vi   = int'(w_v);
  assign o_sat  = (w_vi < MIN_DUTY) || (w_vi > MAX_DUTY);
  assign o_duty = DUTY_BITS'(servo_clamp(w_vi, MIN_DUTY, MAX_DUTY));

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo PWM generator. All channels share one
// prescaler and one frame counter, so they stay phase-aligned.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_valid/wr_ch/data : signed sample write. It is scaled, clamped and
//                         staged in a shadow register until the next frame.
//   ch_en, ch_pol       : per-channel enable / inversion. Both act immediately.
//   pwm_out             : registered PWM outputs
//   sat                 : the last accepted sample for that channel was clamped
//   frame_start         : one-cycle pulse in the first cycle of each frame
//   wr_err              : one-cycle pulse after a write to a missing channel
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int IN_BITS      = 13,
  parameter int DUTY_BITS    = 13,
  parameter int PRESC        = SERVO_PRESC,
  parameter int PERIOD_TICKS = SERVO_PERIOD_TICKS,
  parameter int SHIFT        = 4,
  parameter int OFFSET       = SERVO_OFFSET,
  parameter int MIN_DUTY     = SERVO_MIN_DUTY,
  parameter int MAX_DUTY     = SERVO_MAX_DUTY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  input  logic [3:0]          wr_ch,
  input  logic [IN_BITS-1:0]  wr_data,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [CHANNELS-1:0] ch_pol,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] sat,
  output logic                frame_start,
  output logic                wr_err
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]        PRE_LAST = PW'(PRESC - 1);
  localparam logic [DUTY_BITS-1:0] PER_LAST = DUTY_BITS'(PERIOD_TICKS - 1);
  localparam logic [DUTY_BITS-1:0] DUTY_RST = DUTY_BITS'(OFFSET);

  logic [PW-1:0]        r_pre;
  logic [DUTY_BITS-1:0] r_per;
  logic                 w_tick;
  logic                 w_bnd;
  logic                 w_ch_ok;
  logic                 w_wr_ok;
  logic [DUTY_BITS-1:0] w_duty;
  logic                 w_sat;

  assign w_tick  = (r_pre == PRE_LAST);
  assign w_bnd   = w_tick && (r_per == PER_LAST);
  assign w_ch_ok = (int'(wr_ch) < CHANNELS);
  assign w_wr_ok = wr_valid && w_ch_ok;

  // Shared timebase. With PRESC=1 the prescaler stays at 0, so every cycle is a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre       <= '0;
      r_per       <= '0;
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_per <= (r_per == PER_LAST) ? '0 : r_per + 1'b1;
      frame_start <= w_bnd;
      wr_err      <= wr_valid && !w_ch_ok;
    end
  end

  // One scaler serves all channels, because only one write arrives per cycle.
  servo_scale_sat #(
    .IN_BITS  (IN_BITS),
    .DUTY_BITS(DUTY_BITS),
    .SHIFT    (SHIFT),
    .OFFSET   (OFFSET),
    .MIN_DUTY (MIN_DUTY),
    .MAX_DUTY (MAX_DUTY)
  ) u_scale (
    .i_data(wr_data),
    .o_duty(w_duty),
    .o_sat (w_sat)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DUTY_BITS-1:0] r_act;
    logic [DUTY_BITS-1:0] r_pend;
    logic                 r_flag;
    logic                 r_sat;
    logic                 r_pwm;
    logic                 w_sel;

    assign w_sel = w_wr_ok && (int'(wr_ch) == i);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_act  <= DUTY_RST;
        r_pend <= DUTY_RST;
        r_flag <= 1'b0;
        r_sat  <= 1'b0;
        r_pwm  <= 1'b0;
      end else begin
        // The boundary transfers the value staged before this cycle. A
        // coincident write lands after it, re-arms the flag, and waits one frame.
        if (w_bnd && r_flag) begin
          r_act  <= r_pend;
          r_flag <= 1'b0;
        end
        if (w_sel) begin
          r_pend <= w_duty;
          r_sat  <= w_sat;
          r_flag <= 1'b1;
        end
        r_pwm <= ch_en[i] ? ((r_per < r_act) ^ ch_pol[i]) : ch_pol[i];
      end
    end

    assign pwm_out[i] = r_pwm;
    assign sat[i]     = r_sat;
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a short 10-tick frame. A second
// instance with a non-zero OFFSET checks the neutral width seen after reset.
module tb_servo_pwm_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_ch = '0;
  logic [12:0] wr_data = '0;
  logic [1:0]  ch_en = 2'b11;
  logic [1:0]  ch_pol = 2'b00;
  logic [1:0]  pwm_out, sat;
  logic        frame_start, wr_err;
  logic [0:0]  pwm2, sat2;
  logic        fs2, err2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .CHANNELS(2), .IN_BITS(13), .DUTY_BITS(13), .PRESC(1), .PERIOD_TICKS(10),
    .SHIFT(0), .OFFSET(0), .MIN_DUTY(2), .MAX_DUTY(8)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data),
    .ch_en(ch_en), .ch_pol(ch_pol), .pwm_out(pwm_out), .sat(sat),
    .frame_start(frame_start), .wr_err(wr_err)
  );

  servo_pwm_multi #(
    .CHANNELS(1), .IN_BITS(13), .DUTY_BITS(13), .PRESC(1), .PERIOD_TICKS(10),
    .SHIFT(0), .OFFSET(3), .MIN_DUTY(2), .MAX_DUTY(8)
  ) dut2 (
    .clk(clk), .rst(rst), .wr_valid(1'b0), .wr_ch(4'd0), .wr_data(13'd0),
    .ch_en(1'b1), .ch_pol(1'b0), .pwm_out(pwm2), .sat(sat2),
    .frame_start(fs2), .wr_err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Width w frame pattern: bit j = output while per_cnt == j.
  function automatic logic [9:0] wmask(input int d);
    logic [9:0] m;
    m = '0;
    for (int j = 0; j < 10; j++) if (j < d) m[j] = 1'b1;
    return m;
  endfunction

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1;
    wr_ch    = ch[3:0];
    wr_data  = d[12:0];
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output int n, output logic [1:0] seen);
    n = 0;
    seen = '0;
    while (!frame_start && n < 40) begin
      seen = seen | pwm_out;
      @(negedge clk);
      n++;
    end
    check("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  // Starts at a frame_start negedge; the next 10 samples cover per_cnt 0..9.
  task automatic capture(output logic [9:0] p0, output logic [9:0] p1, output logic [9:0] p2);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      p0[j] = pwm_out[0];
      p1[j] = pwm_out[1];
      p2[j] = pwm2[0];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [1:0] seen;
    logic [9:0] p0, p1, p2, e;

    // reset state
    @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: mid-frame write is deferred to the boundary
    adv(3);
    wr(0, 5);
    check("t1_err", 32'(wr_err), 32'd0);
    check("t1_pre", 32'(pwm_out[0]), 32'd0);
    wait_fs(n, seen);
    check("t1_fs_cnt", 32'(n), 32'd6);
    check("t1_low_frame", 32'(seen[0]), 32'd0);
    check("t1_delay", 32'(pwm_out[0]), 32'd0);
    capture(p0, p1, p2);
    check("t1_w5", 32'(p0), 32'(wmask(5)));
    check("t1_off3", 32'(p2), 32'(wmask(3)));

    // 2: saturation both ways, last write wins
    wr(1, -3);
    check("t2_sat_lo", 32'(sat[1]), 32'd1);
    wr(1, 20);
    check("t2_sat_hi", 32'(sat[1]), 32'd1);
    wait_fs(n, seen);
    capture(p0, p1, p2);
    check("t2_ch1_w8", 32'(p1), 32'(wmask(8)));
    check("t2_ch0_w5", 32'(p0), 32'(wmask(5)));
    wr(1, 4);
    check("t2_sat_clr", 32'(sat[1]), 32'd0);

    // 3: write on the boundary cycle
    wait_fs(n, seen);
    adv(2);
    wr(0, 6);
    adv(6);
    wr(0, 3);
    check("t3_fs", 32'(frame_start), 32'd1);
    capture(p0, p1, p2);
    check("t3_w6", 32'(p0), 32'(wmask(6)));
    check("t3_ch1_w4", 32'(p1), 32'(wmask(4)));
    capture(p0, p1, p2);
    check("t3_w3", 32'(p0), 32'(wmask(3)));

    // 4: polarity, then disable
    wr(0, 5);
    wait_fs(n, seen);
    ch_pol = 2'b01;
    capture(p0, p1, p2);
    e = ~wmask(5);
    check("t4_pol", 32'(p0), 32'(e));
    ch_en = 2'b10;
    adv(1);
    check("t4_dis", 32'(pwm_out[0]), 32'd1);
    capture(p0, p1, p2);
    check("t4_dis_hold", 32'(p0), 32'h3FF);
    ch_en  = 2'b11;
    ch_pol = 2'b00;

    // 5: write to a missing channel
    wr(3, 7);
    check("t5_err", 32'(wr_err), 32'd1);
    check("t5_sat", 32'(sat), 32'd0);
    adv(1);
    check("t5_err_pulse", 32'(wr_err), 32'd0);
    wait_fs(n, seen);
    capture(p0, p1, p2);
    check("t5_ch0", 32'(p0), 32'(wmask(5)));
    check("t5_ch1", 32'(p1), 32'(wmask(4)));

    // 6: reset mid-frame
    wr(0, 7);
    wait_fs(n, seen);
    adv(4);
    check("t6_pre_hi", 32'(pwm_out[0]), 32'd1);
    wr(1, 30);
    check("t6_sat_pre", 32'(sat[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_pwm", 32'(pwm_out), 32'd0);
    check("t6_async_sat", 32'(sat), 32'd0);
    check("t6_async_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_fs(n, seen);
    check("t6_fs_cnt", 32'(n), 32'd10);
    check("t6_low_frame", 32'(seen), 32'd0);
    check("t6_fs_align", 32'(fs2), 32'(frame_start));
    check("t6_dut2_flags", 32'({sat2, err2}), 32'd0);
    capture(p0, p1, p2);
    check("t6_ch0_off", 32'(p0), 32'(wmask(0)));
    check("t6_ch1_lost", 32'(p1), 32'(wmask(0)));
    check("t6_off3", 32'(p2), 32'(wmask(3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Parametrised multi-channel servo PWM generator that replaces the single-channel truncate-then-PWM path behind the IPD controller. It accepts signed controller outputs per channel, scales, offsets and saturates each one into a legal servo pulse width. New widths are double-buffered and applied only at frame boundaries, which keeps pulses glitch-free. All channels share one prescaler and one frame counter, so they stay phase-aligned; per-channel enable and polarity are added.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
IN_BITS, 13, width of signed controller sample
DUTY_BITS, 13, width of frame counter and duty values; must hold PERIOD_TICKS
PRESC, 390, clk cycles per tick (>=1)
PERIOD_TICKS, 5128, ticks per frame (50 Hz at 100 MHz)
SHIFT, 4, arithmetic right shift applied to the sample
OFFSET, 384, added after shift; neutral pulse width in ticks
MIN_DUTY, 256, lower clamp (1 ms)
MAX_DUTY, 512, upper clamp (2 ms)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_valid  in  1  sample write strobe
wr_ch  in  4  target channel index
wr_data  in  IN_BITS  signed controller sample
ch_en  in  CHANNELS  per-channel enable
ch_pol  in  CHANNELS  1 = inverted output
pwm_out  out  CHANNELS  PWM outputs
sat  out  CHANNELS  1 = last accepted sample on that channel was clamped
frame_start  out  1  one-cycle pulse, first cycle of each frame
wr_err  out  1  one-cycle pulse, write to a nonexistent channel

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high. All state is reset asynchronously.
- Reset values:
  - pwm_out=0, sat=0, frame_start=0, wr_err=0
  - Prescaler and frame counter = 0
  - duty_act[i] = duty_pend[i] = OFFSET; pend_flag[i] = 0
- Prescaler: pre_cnt counts 0..PRESC-1. tick = (pre_cnt==PRESC-1). With PRESC=1, tick is asserted every cycle.
- Frame counter: per_cnt advances on tick and wraps from PERIOD_TICKS-1 to 0.
- Frame boundary: the cycle where tick && per_cnt==PERIOD_TICKS-1.
  - On the clock edge ending that cycle, every channel with pend_flag=1 loads duty_act <= duty_pend and clears pend_flag.
  - frame_start is registered high for exactly the following cycle (the cycle with per_cnt=0).
- Write path, one cycle:
  - On wr_valid with wr_ch < CHANNELS: v = (wr_data >>> SHIFT) + OFFSET, computed sign-extended at IN_BITS+2 bits.
  - duty_pend[wr_ch] <= clamp(v, MIN_DUTY, MAX_DUTY).
  - sat[wr_ch] <= (v<MIN_DUTY || v>MAX_DUTY).
  - pend_flag[wr_ch] <= 1.
  - No backpressure; one write per cycle is always accepted.
  - If wr_ch >= CHANNELS: state unchanged, and wr_err pulses for the next cycle.
- Multiple writes to one channel within a frame: the last write wins.
- Write in the same cycle as a frame boundary: the boundary transfers the pre-existing pending value. The new write lands in duty_pend and takes effect at the next boundary.
- Output:
  - pwm_raw[i] = (per_cnt < duty_act[i]).
  - pwm_out[i] is registered: ch_en[i] ? (pwm_raw[i] ^ ch_pol[i]) : ch_pol[i].
  - Latency is 1 cycle from per_cnt to pwm_out.
- ch_en and ch_pol are sampled every cycle and take effect immediately (not double-buffered).
- duty_act=0 gives a constant inactive level. duty_act >= PERIOD_TICKS gives a constant active level. The clamp range normally prevents both.
- Reset mid-frame: outputs drop to 0 immediately. After release, the frame restarts at per_cnt=0 with neutral OFFSET width. Pending writes are lost.

Decomposition:
- Shared package/header servo_pkg: default timing constants (PRESC, PERIOD_TICKS, MIN_DUTY, MAX_DUTY, OFFSET) and a clamp function.
- One natural sub-module, servo_scale_sat: combinational shift + offset + clamp that produces duty and a saturation flag. Instantiated once on the write path.
- Frame timebase and per-channel shadow/compare registers stay in the top of this block, using a generate loop.

Test Plan:
1. CHANNELS=2, PRESC=1, PERIOD_TICKS=10, SHIFT=0, OFFSET=0, MIN=2, MAX=8; write ch0=5 mid-frame -> ch0 keeps its reset duty (0 = constant low) until the boundary. From the next frame, pwm_out[0] is high for 5 cycles and low for 5, delayed 1 cycle after frame_start.
2. Same config; write ch1=-3, then ch1=20 -> duty_pend 2 then 8; sat[1]=1 after each. Next frame: high 8 cycles. Then write ch1=4 -> sat[1]=0.
3. Write ch0=3 exactly on the boundary cycle while pend=6 -> next frame width 6, following frame width 3.
4. ch_pol[0]=1 with duty 5 -> low 5, high 5. Then ch_en[0]=0 -> pwm_out[0] held 1 from the next cycle.
5. wr_ch=3 with CHANNELS=2 -> wr_err pulses 1 cycle; duty, sat and pwm unchanged.
6. Assert rst mid-frame with duty 7 -> pwm_out=0 asynchronously. After release: frame_start after 10 cycles; with default OFFSET, width equals the OFFSET value.
